// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and baud divider.
// Optional parity bit: define UART_CONST_BAUD_TX_PARITY_EN to widen the state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned BIT_IDX_W   = 4;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        IDLE_LEVEL  = 1'b1;

`ifdef UART_CONST_BAUD_TX_PARITY_EN
  localparam int unsigned STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_e;
`else
  localparam int unsigned STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;
`endif

  // Clock cycles per bit; truncating division, same as the receiver.
  function automatic int unsigned baud_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..limit-1 while enabled, held clear otherwise.
module uart_baud_tick #(
  parameter int unsigned limit = 2,
  parameter int unsigned cnt_w = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [cnt_w-1:0] count,
  output logic             tc_c
);

  logic [cnt_w-1:0] count_d, count_q;

  // Terminal count marks the last cycle of the current bit.
  assign tc_c  = en && (count_q == cnt_w'(limit - 1));
  assign count = count_q;

  // Next count: clear when disabled or at terminal count, else increment.
  always_comb begin
    count_d = count_q;
    if (!en || tc_c) begin
      count_d = '0;
    end else begin
      count_d = count_q + cnt_w'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_const_baud_tx.sv
// Fixed-baud UART transmitter, 8N1 LSB first (8E1/8O1 when
// UART_CONST_BAUD_TX_PARITY_EN is defined). All outputs registered.
module uart_const_baud_tx
  import uart_pkg::*;
#(
  parameter int unsigned clock_freq = 100_000_000,
  parameter int unsigned baud_rate  = 115200,
  parameter int unsigned parity_odd = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BAUD_LIMIT = baud_div(clock_freq, baud_rate);
  localparam int unsigned CNT_W      = (BAUD_LIMIT > 1) ? $clog2(BAUD_LIMIT) : 1;

  if (BAUD_LIMIT < 2 || parity_odd > 1) begin : g_bad_cfg
    $error("uart_const_baud_tx: baud_limit must be >= 2 and parity_odd must be 0 or 1");
  end

  tx_state_e                state_d, state_q;
  logic [DATA_BITS-1:0]     shift_d, shift_q;
  logic [BIT_IDX_W-1:0]     bit_idx_d, bit_idx_q;
  logic                     tx_d, tx_q;
  logic                     busy_d, busy_q;
  logic                     done_d, done_q;
  logic [CNT_W-1:0]         cnt;
  logic                     tick_c;
`ifdef UART_CONST_BAUD_TX_PARITY_EN
  logic                     par_d, par_q;
`endif

  uart_baud_tick #(
    .limit (BAUD_LIMIT),
    .cnt_w (CNT_W)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q != IDLE),
    .count (cnt),
    .tc_c  (tick_c)
  );

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
`ifdef UART_CONST_BAUD_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        bit_idx_d = '0;
        if (send) begin
          shift_d = data;
`ifdef UART_CONST_BAUD_TX_PARITY_EN
          par_d   = (^data) ^ 1'(parity_odd);
`endif
          state_d = START;
        end
      end
      START: begin
        if (tick_c) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick_c) begin
          shift_d   = {IDLE_LEVEL, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_CONST_BAUD_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_CONST_BAUD_TX_PARITY_EN
      PARITY: begin
        if (tick_c) begin
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_c) begin
          bit_idx_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx switches with the state.
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_CONST_BAUD_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE);
    // Counter reaches limit-1 on the next edge: that is the final stop cycle.
    done_d = (state_q == STOP) && (cnt == CNT_W'(BAUD_LIMIT - 2));
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '1;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_CONST_BAUD_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_CONST_BAUD_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_const_baud_tx.sv
// Scoreboard bench for uart_const_baud_tx: stimulus pushes expected frames,
// a line monitor decodes tx like a receiver and compares against the queue.
`timescale 1ns/1ps
module tb_uart_const_baud_tx;

  localparam int unsigned CLK_F   = 1_000_000;
  localparam int unsigned BAUD    = 100_000;
  localparam int          BL      = 10;
  localparam int unsigned PAR_ODD = 0;
`ifdef UART_CONST_BAUD_TX_PARITY_EN
  localparam int NBITS    = 11;
  localparam int EXP_DONE = 9;
`else
  localparam int NBITS    = 10;
  localparam int EXP_DONE = 8;
`endif

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_frames = 0;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, busy, done;

  always #5 clk = ~clk;

  uart_const_baud_tx #(
    .clock_freq (CLK_F),
    .baud_rate  (BAUD),
    .parity_odd (PAR_ODD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .send (send),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done === 1'b1) n_done++;
  end

  // Line monitor: decode each frame, check bit hold, busy and done placement.
  initial begin : monitor
    logic             prev_tx;
    int               idle_cnt;
    int               gap_seen;
    logic [NBITS-1:0] lvl;
    logic             stable, busy_ok, done_ok, aborted;
    exp_t             e;
    prev_tx  = 1'b1;
    idle_cnt = 1000;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_tx  = 1'b1;
        idle_cnt = 1000;
      end else if (prev_tx === 1'b1 && tx === 1'b0) begin
        gap_seen = idle_cnt;
        stable = 1'b1; busy_ok = 1'b1; done_ok = 1'b1; aborted = 1'b0; lvl = '0;
        for (int b = 0; b < NBITS && !aborted; b++) begin
          for (int c = 0; c < BL; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (c == 0) lvl[b] = tx;
            else if (tx !== lvl[b]) stable = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if ((done === 1'b1) != (b == NBITS - 1 && c == BL - 1)) done_ok = 1'b0;
          end
        end
        if (!aborted) begin
          n_frames++;
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got frame data %0h expected no frame", lvl[8:1]);
          end else begin
            e = sb_q.pop_front();
            chk("start_bit", 32'(lvl[0]), 32'd0);
            chk("data_byte", 32'(lvl[8:1]), 32'(e.data));
            chk("stop_bit", 32'(lvl[NBITS-1]), 32'd1);
            chk("bit_hold", 32'(stable), 32'd1);
            chk("busy_in_frame", 32'(busy_ok), 32'd1);
            chk("done_position", 32'(done_ok), 32'd1);
`ifdef UART_CONST_BAUD_TX_PARITY_EN
            chk("parity_bit", 32'(lvl[9]), 32'((^e.data) ^ 1'(PAR_ODD)));
`endif
            if (e.gap >= 0) chk("idle_gap", 32'(gap_seen), 32'(e.gap));
          end
        end
        prev_tx  = 1'b1;
        idle_cnt = aborted ? 1000 : 0;
      end else begin
        idle_cnt++;
        prev_tx = tx;
      end
    end
  end

  task automatic pulse_send(input logic [7:0] d);
    @(posedge clk); #1;
    data = d;
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  // Count busy cycles until busy drops; bounded.
  task automatic wait_idle(output int cyc);
    int guard;
    cyc   = 0;
    guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (busy === 1'b1) cyc++;
      else break;
      if (guard > 2000) begin
        chk("wait_idle_timeout", 32'(guard), 32'd2000);
        break;
      end
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        chk("wait_done_timeout", 32'(guard), 32'd2000);
        break;
      end
    end
  endtask

  initial begin : stimulus
    int         cyc;
    logic [7:0] lb [3];
    exp_t       e;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'hA3;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Single frame 0x55
    e.data = 8'h55; e.gap = -1; sb_q.push_back(e);
    pulse_send(8'h55);
    @(negedge clk);
    chk("accept_tx", 32'(tx), 32'd0);
    chk("accept_busy", 32'(busy), 32'd1);
    wait_idle(cyc);
    chk("busy_len_single", 32'(cyc + 1), 32'(NBITS * BL));

    // Send during DATA is ignored
    e.data = 8'h00; e.gap = -1; sb_q.push_back(e);
    pulse_send(8'h00);
    repeat (35) @(posedge clk); #1;
    data = 8'hFF;
    send = 1'b1;
    repeat (5) @(posedge clk); #1;
    send = 1'b0;
    data = 8'h00;
    wait_idle(cyc);
    repeat (30) @(posedge clk);
    chk("reject_done_count", 32'(n_done), 32'd2);

    // Back-to-back with send held high
    e.data = 8'hA3; e.gap = -1; sb_q.push_back(e);
    e.data = 8'h3A; e.gap = 1;  sb_q.push_back(e);
    @(posedge clk); #1;
    data = 8'hA3;
    send = 1'b1;
    @(posedge clk); #1;
    data = 8'h3A;
    wait_done();
    @(posedge clk);
    @(posedge clk); #1;
    send = 1'b0;
    wait_idle(cyc);
    chk("busy_len_b2b", 32'(cyc), 32'(NBITS * BL));

    // Reset during bit 4 of 0x0F, then a clean 0x81
    pulse_send(8'h0F);
    repeat (53) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_tx", 32'(tx), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    e.data = 8'h81; e.gap = -1; sb_q.push_back(e);
    pulse_send(8'h81);
    wait_idle(cyc);

    // Receiver-style loopback bytes
    for (int i = 0; i < 3; i++) begin
      e.data = lb[i]; e.gap = -1; sb_q.push_back(e);
      pulse_send(lb[i]);
      wait_idle(cyc);
    end

`ifdef UART_CONST_BAUD_TX_PARITY_EN
    e.data = 8'h07; e.gap = -1; sb_q.push_back(e);
    pulse_send(8'h07);
    wait_idle(cyc);
`endif

    repeat (20) @(posedge clk);
    chk("total_done", 32'(n_done), 32'(EXP_DONE));
    chk("total_frames", 32'(n_frames), 32'(EXP_DONE));
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got simulation time limit expected end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
